// File: rtl/count_bcd_display_if.sv
// count_bcd_display_if: bus between the counter side and the BCD display block.
//   value    - 8-bit binary value to convert
//   load     - sample strobe
//   busy     - conversion in progress
//   done     - one-cycle pulse when a new result is latched
//   bcd_out  - latched {hundreds, tens, units}
//   seg      - 7-segment drive, seg[0]=a .. seg[6]=g
//   digit_en - one-hot digit select (bit0=units, bit1=tens, bit2=hundreds)
interface count_bcd_display_if;
   logic [7:0]  value;
   logic        load;
   logic        busy;
   logic        done;
   logic [11:0] bcd_out;
   logic [6:0]  seg;
   logic [2:0]  digit_en;

   modport master (output value, load,
                   input  busy, done, bcd_out, seg, digit_en);
   modport slave  (input  value, load,
                   output busy, done, bcd_out, seg, digit_en);
endinterface

// File: rtl/count_bcd_display.sv
// count_bcd_display: samples an 8-bit binary value on load, converts it to
// three BCD digits with a sequential double-dabble engine (one bit per
// cycle), and scans the latched result onto a 3-digit 7-segment display.
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - count_bcd_display_if.slave (value/load in; busy/done/bcd_out/
//         seg/digit_en out)
// Parameters:
//   SCAN_DIV       - clk cycles each digit stays enabled (2..65536)
//   SEG_ACTIVE_LOW - 1 inverts seg and digit_en at the output
// Optional feature:
//   LEADING_ZERO_BLANK_EN - when defined, blanks a zero hundreds digit and a
//   zero tens digit that follows a zero hundreds digit.
module count_bcd_display #(
   parameter int SCAN_DIV       = 1024,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   count_bcd_display_if.slave   bus
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t      state, state_nxt;
   logic [7:0]  bin;
   logic [11:0] scratch;
   logic [11:0] adj;
   logic [11:0] bcd_q;
   logic [2:0]  iter;
   logic        done_q;

   logic [DW-1:0] div;
   logic [1:0]    idx, idx_nxt;
   logic [2:0]    den;
   logic [3:0]    nib;
   logic [6:0]    seg_raw;

   // ---------------- conversion FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.load) state_nxt = SHIFT;
         SHIFT:   if (iter == 3'd7) state_nxt = LATCH;
         LATCH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 correction on every nibble that would overflow past 9 when doubled.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 3; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin     <= '0;
         scratch <= '0;
         iter    <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: if (bus.load) begin
               bin     <= bus.value;
               scratch <= '0;
               iter    <= '0;
            end
            SHIFT: begin
               {scratch, bin} <= {adj[10:0], bin, 1'b0};
               iter           <= iter + 3'd1;
            end
            LATCH: begin
               bcd_q  <= scratch;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- display scan ----------------
   // Divider free-runs regardless of the FSM; digit_en is registered together
   // with the index so both change on the same edge.
   assign idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
         idx <= 2'd0;
         den <= 3'b001;
      end else if (div == DW'(SCAN_DIV - 1)) begin
         div <= '0;
         idx <= idx_nxt;
         den <= 3'b001 << idx_nxt;
      end else begin
         div <= div + 1'b1;
      end
   end

   function automatic logic [6:0] glyph(input logic [3:0] n);
      unique case (n)
         4'd0:    glyph = 7'h3F;
         4'd1:    glyph = 7'h06;
         4'd2:    glyph = 7'h5B;
         4'd3:    glyph = 7'h4F;
         4'd4:    glyph = 7'h66;
         4'd5:    glyph = 7'h6D;
         4'd6:    glyph = 7'h7D;
         4'd7:    glyph = 7'h07;
         4'd8:    glyph = 7'h7F;
         4'd9:    glyph = 7'h6F;
         default: glyph = 7'h00;
      endcase
   endfunction

   always_comb begin
      unique case (idx)
         2'd0:    nib = bcd_q[3:0];
         2'd1:    nib = bcd_q[7:4];
         default: nib = bcd_q[11:8];
      endcase
      seg_raw = glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 2'd2 && bcd_q[11:8] == 4'd0) seg_raw = 7'h00;
      if (idx == 2'd1 && bcd_q[11:4] == 8'd0) seg_raw = 7'h00;
`else
      // All digits always show their glyph.
`endif
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.bcd_out  = bcd_q;
   assign bus.seg      = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
   assign bus.digit_en = SEG_ACTIVE_LOW ? ~den : den;

endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display: directed bench for count_bcd_display (SCAN_DIV=4,
// active-high outputs). Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_count_bcd_display;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   count_bcd_display_if bus ();

   count_bcd_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] gl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Drive load for one cycle and wait (bounded) for done. cyc is the number
   // of falling edges until done is seen, bcnt the falling edges with busy=1.
   task automatic run_load(input logic [7:0] v, output int cyc, output int bcnt);
      bus.value = v;
      bus.load  = 1'b1;
      cyc  = 0;
      bcnt = 0;
      do begin
         @(negedge clk);
         bus.load = 1'b0;
         cyc++;
         if (bus.busy) bcnt++;
      end while (!bus.done && cyc < 30);
      if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   // Find the hundreds->units wrap, then check three full digit periods.
   task automatic check_scan(input string tag, input logic [11:0] b);
      logic [2:0] prev;
      logic [6:0] exp_seg;
      logic [3:0] n;
      int         d;
      bit         found = 0;
      prev = bus.digit_en;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (prev == 3'b100 && bus.digit_en == 3'b001) found = 1;
         prev = bus.digit_en;
      end
      if (!found) chk({tag, "_scan_timeout"}, 32'd0, 32'd1);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         d = (i / 4) % 3;
         n = b[4*d +: 4];
         exp_seg = gl[n];
`ifdef LEADING_ZERO_BLANK_EN
         if (d == 2 && b[11:8] == 4'd0) exp_seg = 7'h00;
         if (d == 1 && b[11:4] == 8'd0) exp_seg = 7'h00;
`endif
         chk({tag, "_digit_en"}, 32'(bus.digit_en), 32'(3'b001 << d));
         chk({tag, "_seg"},      32'(bus.seg),      32'(exp_seg));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, bcnt;
      rst       = 1'b1;
      bus.load  = 1'b0;
      bus.value = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_done",     32'(bus.done),     32'd0);
      chk("rst_bcd",      32'(bus.bcd_out),  32'h000);
      chk("rst_digit_en", 32'(bus.digit_en), 32'b001);
      chk("rst_seg",      32'(bus.seg),      32'h3F);
      rst = 1'b0;

      // 255: latency, busy length, one-cycle done pulse.
      run_load(8'd255, cyc, bcnt);
      chk("lat255",   cyc,                   32'd10);
      chk("busy255",  bcnt,                  32'd9);
      chk("busy_at_done", 32'(bus.busy),     32'd0);
      chk("bcd255",   32'(bus.bcd_out),      32'h255);
      @(negedge clk);
      chk("done_pulse", 32'(bus.done),       32'd0);

      run_load(8'd0,   cyc, bcnt);
      chk("bcd0",     32'(bus.bcd_out),      32'h000);
      run_load(8'd9,   cyc, bcnt);
      chk("bcd9",     32'(bus.bcd_out),      32'h009);
      run_load(8'd100, cyc, bcnt);
      chk("bcd100",   32'(bus.bcd_out),      32'h100);

      // Exhaustive sweep; each load issued in the previous done cycle.
      for (int v = 0; v < 256; v++) begin
         run_load(8'(v), cyc, bcnt);
         chk("sweep", 32'(bus.bcd_out), 32'(to_bcd(v)));
      end

      // Load while busy is ignored; the sampled copy is what converts.
      @(negedge clk);
      bus.value = 8'd42;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
      bus.value = 8'd13;
      repeat (2) @(negedge clk);
      bus.value = 8'd99;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
      bus.value = 8'd7;
      cyc = 0;
      while (!bus.done && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk("ign_lat", cyc, 32'd6);
      chk("ign_bcd", 32'(bus.bcd_out), 32'h042);
      run_load(8'd99, cyc, bcnt);
      chk("done_cycle_load_lat", cyc, 32'd10);
      chk("done_cycle_load_bcd", 32'(bus.bcd_out), 32'h099);

      // Display scan.
      run_load(8'd123, cyc, bcnt);
      chk("bcd123", 32'(bus.bcd_out), 32'h123);
      check_scan("scan123", 12'h123);

      // Reset mid-conversion.
      @(negedge clk);
      bus.value = 8'd200;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mrst_busy",     32'(bus.busy),     32'd0);
      chk("mrst_done",     32'(bus.done),     32'd0);
      chk("mrst_bcd",      32'(bus.bcd_out),  32'h000);
      chk("mrst_digit_en", 32'(bus.digit_en), 32'b001);
      chk("mrst_seg",      32'(bus.seg),      32'h3F);
      @(negedge clk);
      rst = 1'b0;

      run_load(8'd5, cyc, bcnt);
      chk("bcd5", 32'(bus.bcd_out), 32'h005);
      check_scan("scan005", 12'h005);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
